// File: rtl/multiplier_radix.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Optional feature: define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic                 signed1,
  input  logic                 signed2,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = WIDTH + BITS_PER_CYCLE;

  generate
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_radix
      $error("multiplier_radix: BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     m_q, acc_q, q_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 accept, step;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [PW-1:0]        partial;
  logic [PW-1:0]        q_shift;
  logic [2*WIDTH-1:0]   raw;

  // Handshake: a start is taken on a rising edge where start_i & ready_o & ~flush_i;
  // done_o pulses for exactly one cycle when product_o has just been written.
  assign ready_o = (state == IDLE) || (state == DONE);
  assign done_o  = (state == DONE);
  assign accept  = start_i & ready_o & ~flush_i;

  assign a_mag   = (signed1 && multiplicand_i[WIDTH-1]) ? -multiplicand_i : multiplicand_i;
  assign b_mag   = (signed2 && multiplier_i[WIDTH-1])   ? -multiplier_i   : multiplier_i;

  assign partial = PW'(acc_q) + PW'(m_q) * PW'(q_q[BITS_PER_CYCLE-1:0]);
  assign q_shift = {partial[BITS_PER_CYCLE-1:0], q_q};

`ifdef MULT_EARLY_TERM_EN
  localparam int SH_W = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] rem_q;
  logic             rem_zero;
  logic [SH_W-1:0]  shamt;

  // Stopping early leaves {acc,q} left-aligned; realign by the bits never shifted in.
  assign rem_zero = (rem_q == '0);
  assign shamt    = SH_W'(WIDTH) - SH_W'(cnt_q) * SH_W'(BITS_PER_CYCLE);
  assign raw      = {acc_q, q_q} >> shamt;
  assign step     = (state == RUN) && !flush_i && !rem_zero;
`else
  logic last_iter;

  assign last_iter = (cnt_q == CNT_W'(N - 1));
  assign raw       = {acc_q, q_q};
  assign step      = (state == RUN) && !flush_i;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = RUN;
`ifdef MULT_EARLY_TERM_EN
      RUN:   if (rem_zero) state_next = FIXUP;
`else
      RUN:   if (last_iter) state_next = FIXUP;
`endif
      FIXUP: state_next = DONE;
      DONE:  state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      product_o <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
      rem_q     <= '0;
`endif
    end else if (accept) begin
      m_q   <= a_mag;
      q_q   <= b_mag;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= (signed1 & multiplicand_i[WIDTH-1]) ^ (signed2 & multiplier_i[WIDTH-1]);
`ifdef MULT_EARLY_TERM_EN
      rem_q <= b_mag;
`endif
    end else if (step) begin
      acc_q <= partial[PW-1:BITS_PER_CYCLE];
      q_q   <= q_shift[PW-1:BITS_PER_CYCLE];
      cnt_q <= cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
      rem_q <= rem_q >> BITS_PER_CYCLE;
`endif
    end else if (state == FIXUP && !flush_i) begin
      product_o <= neg_q ? -raw : raw;
    end
  end

endmodule

// File: tb/tb_multiplier_radix.sv
// Randomized self-checking bench for multiplier_radix against a plain-arithmetic product model.
// Expected latency follows MULT_EARLY_TERM_EN when the bench is built with that macro.
module tb_multiplier_radix;
  localparam int W = 32;
  localparam int B = 2;
  localparam int N = W / B;

  logic           clk = 1'b0;
  logic           rst, start, flush, s1, s2;
  logic [W-1:0]   a, b;
  logic           ready, done;
  logic [2*W-1:0] product;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;
  int             n_checks = 0;
  int             n_pass   = 0;

  multiplier_radix #(.WIDTH(W), .BITS_PER_CYCLE(B)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .signed1(s1), .signed2(s2), .multiplicand_i(a), .multiplier_i(b),
    .ready_o(ready), .done_o(done), .product_o(product)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic xs, input logic ys);
    logic [63:0] xe, ye;
    xe = xs ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = ys ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] y, input logic ys);
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] mag;
    int bl;
    mag = (ys && y[W-1]) ? -y : y;
    bl = 0;
    for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
    return (bl + B - 1) / B + 2;
`else
    if (ys && y[W-1]) return N + 1;
    return N + 1;
`endif
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic xs, input logic ys);
    @(negedge clk);
    check("ready_at_start", {63'b0, ready}, 64'd1);
    start = 1'b1; a = x; b = y; s1 = xs; s2 = ys;
    exp_q.push_back(model(x, y, xs, ys));
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; s1 = 1'($urandom); s2 = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    logic [63:0] e;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && !done) check("busy_ready", {63'b0, ready}, 64'd0);
    end while (!done && lat < 200);
    if (!done) begin
      check("done_timeout", 64'd0, 64'd1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
    end else if (exp_q.size() == 0) begin
      check("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("product", product, e);
      last_exp = e;
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic xs, input logic ys);
    int lat;
    start_op(x, y, xs, ys);
    wait_done(lat);
    check("latency", 64'(lat), 64'(exp_lat(y, ys)));
    @(posedge clk); #1;
    check("done_pulse_drop", {63'b0, done}, 64'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check(tag, {63'b0, seen}, 64'd0);
  endtask

  logic [W-1:0]  dir_a [9] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                               32'h80000001, 32'h00000000, 32'h12345678, 32'h12345678,
                               32'hFFFFFFFF};
  logic [W-1:0]  dir_b [9] = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'hFFFFFFFF,
                               32'h00000003, 32'hFFFFFFFF, 32'h00000000, 32'h00000001,
                               32'hFFFFFFFF};
  logic          dir_s1[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic          dir_s2[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0]   dir_p [9] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB,
                               64'h40000000_00000000, 64'hFFFFFFFF_00000001,
                               64'h00000001_80000003, 64'h00000000_00000000,
                               64'h00000000_00000000, 64'h00000000_12345678,
                               64'h00000000_00000001};

  logic [W-1:0] corners[4] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000001};

  initial begin
    int lat, lat2;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; s1 = 1'b0; s2 = 1'b0; a = '0; b = '0;
    last_exp = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'b0, ready}, 64'd1);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(dir_a[i], dir_b[i], dir_s1[i], dir_s2[i]);
      check("directed_const", product, dir_p[i]);
    end

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      if ($urandom_range(0, 4) == 0) rb = W'($urandom_range(0, 255));
      run_op(ra, rb, 1'($urandom), 1'($urandom));
    end

    // A start pulse while busy must not disturb the running operation.
    start_op(32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_ready", {63'b0, ready}, 64'd0);
    wait_done(lat);
    check("busy_latency", 64'(lat + 3), 64'(exp_lat(32'hFFFFFFFF, 1'b0)));
    @(posedge clk); #1;

    // Flush mid-run: back to idle, no done, product keeps the previous result.
    start_op(W'($urandom), 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_ready", {63'b0, ready}, 64'd1);
    check("flush_done", {63'b0, done}, 64'd0);
    void'(exp_q.pop_front());
    expect_quiet("flush_no_done", 30);
    check("flush_product_held", product, last_exp);

    // Flush beats a simultaneous start in idle.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; a = 32'h5; b = 32'h6;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_prio_ready", {63'b0, ready}, 64'd1);
    expect_quiet("flush_prio_no_done", 30);

    // Back-to-back: second start lands in the done cycle.
    start_op(32'hFFFFFFF9, 32'h00000013, 1'b1, 1'b0);
    wait_done(lat);
    check("b2b_lat1", 64'(lat), 64'(exp_lat(32'h00000013, 1'b0)));
    start_op(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
    wait_done(lat2);
    check("b2b_lat2", 64'(lat2), 64'(exp_lat(32'h80000000, 1'b1)));
    check("b2b_const", product, 64'hC0000000_80000000);
    @(posedge clk); #1;

    // Reset mid-run behaves as flush and clears the product.
    start_op(32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_ready", {63'b0, ready}, 64'd1);
    check("midrun_rst_product", product, 64'd0);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    expect_quiet("midrun_rst_no_done", 30);

    run_op(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
